irda_receiver: RTL

//  Downstream stage of the IrDA transmitter: decodes the IR pulse stream (idle low, one high

---
 rtl/irda_receiver.sv | 130 +++++++++++++
 1 files changed

// File: rtl/irda_receiver.sv
// IrDA pulse-stream receiver: synchronizes and glitch-filters the IR input, then decodes
// start, seven LSB-first data bits, parity and stop into a word with a one-cycle valid strobe.
module irda_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MIN_PULSE    = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rxd_ir,
  output logic [6:0] data_rxd,
  output logic       valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int RW = $clog2(MIN_PULSE + 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] START_LAST = CW'(3 * CLKS_PER_BIT / 4 - 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(MIN_PULSE);
  localparam logic [RW-1:0] RUN_ARM    = RW'(MIN_PULSE - 1);
  localparam logic          ODD        = (ODD_PARITY != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [RW-1:0] run;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic          flag;
  logic [6:0]    shift;
  logic          rx_parity;
  logic          valid_reg;
  logic          rx_sync;
  logic          seen;
  logic          flag_eff;

  assign rx_sync  = sync[1];
  // A pulse counts once, on the cycle its high run reaches MIN_PULSE.
  assign seen     = ena && rx_sync && (run == RUN_ARM);
  assign flag_eff = flag | seen;
  assign valid    = valid_reg & ena;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
      run  <= '0;
    end else if (ena) begin
      sync <= {sync[0], rxd_ir};
      if (!rx_sync)
        run <= '0;
      else if (run != RUN_MAX)
        run <= run + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= 4'd0;
      flag         <= 1'b0;
      shift        <= 7'd0;
      rx_parity    <= 1'b0;
      data_rxd     <= 7'd0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      valid_reg    <= 1'b0;
      busy         <= 1'b0;
    end else if (!ena) begin
      // A strobe interrupted by ena is dropped, never replayed.
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (seen && !valid_reg) begin
            state <= START;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == START_LAST) begin
            state   <= DATA;
            cnt     <= '0;
            flag    <= 1'b0;
            bit_idx <= 4'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA, PARITY, STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            flag    <= 1'b0;
            bit_idx <= bit_idx + 4'd1;
            if (state == DATA) begin
              shift <= {~flag_eff, shift[6:1]};
              if (bit_idx == 4'd7)
                state <= PARITY;
            end else if (state == PARITY) begin
              rx_parity <= ~flag_eff;
              state     <= STOP;
            end else begin
              // A pulse in the stop window means the stop bit read as 0.
              data_rxd     <= shift;
              parity_error <= rx_parity != ((^shift) ^ ODD);
              frame_error  <= flag_eff;
              valid_reg    <= 1'b1;
              busy         <= 1'b0;
              bit_idx      <= 4'd0;
              state        <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (seen)
              flag <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
